// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared definitions for the frame-synchronous control
// register scheduler.
//   - register id codes (shared with the SPI command decoder)
//   - FSM state encoding
//   - write request payload
//   - field width helpers derived from PRECISION
package pipeline_ctrl_pkg;

   // Register id codes, same numbering as the SPI command decoder
   localparam logic [7:0] REG_CLEAR         = 8'h00;
   localparam logic [7:0] REG_MODE          = 8'h01;
   localparam logic [7:0] REG_RESERVED_02   = 8'h02;
   localparam logic [7:0] REG_SCALE         = 8'h03;
   localparam logic [7:0] REG_OFFSET_X      = 8'h04;
   localparam logic [7:0] REG_OFFSET_Y      = 8'h05;
   localparam logic [7:0] REG_RESERVED_06   = 8'h06;
   localparam logic [7:0] REG_CLIP_LEFT     = 8'h07;
   localparam logic [7:0] REG_CLIP_RIGHT    = 8'h08;
   localparam logic [7:0] REG_CLIP_TOP      = 8'h09;
   localparam logic [7:0] REG_CLIP_BOTTOM   = 8'h0A;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_e;

   // Decoder write request payload
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   // Signed offsets carry one extra bit over the clip range
   function automatic int unsigned off_w(input int unsigned precision);
      return precision + 1;
   endfunction

   function automatic int unsigned clip_w(input int unsigned precision);
      return precision;
   endfunction

   // True for every id that lands in (or clears) the shadow registers
   function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
      return (addr == REG_CLEAR)    || (addr == REG_MODE)       ||
             (addr == REG_SCALE)    || (addr == REG_OFFSET_X)   ||
             (addr == REG_OFFSET_Y) || (addr == REG_CLIP_LEFT)  ||
             (addr == REG_CLIP_RIGHT) || (addr == REG_CLIP_TOP) ||
             (addr == REG_CLIP_BOTTOM);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_shadow_regs.sv
// pipeline_ctrl_shadow_regs: address decode and shadow storage for the
// control registers. Accepted writes update one field (or clear all).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   wr_fire         write handshake completed this cycle
//   wr_req          address/data of the write
//   shd_*           shadow field values (registered)
//   mapped_wr_c     combinational: accepted write hit a mapped id
import pipeline_ctrl_pkg::*;

module pipeline_ctrl_shadow_regs #(
   parameter int unsigned PRECISION = 11
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  wr_fire,
   input  wr_req_t                               wr_req,
   output logic [1:0]                            shd_mode,
   output logic [1:0]                            shd_scale,
   output logic signed [off_w(PRECISION)-1:0]    shd_offset_x,
   output logic signed [off_w(PRECISION)-1:0]    shd_offset_y,
   output logic [clip_w(PRECISION)-1:0]          shd_clip_left,
   output logic [clip_w(PRECISION)-1:0]          shd_clip_right,
   output logic [clip_w(PRECISION)-1:0]          shd_clip_top,
   output logic [clip_w(PRECISION)-1:0]          shd_clip_bottom,
   output logic                                  mapped_wr_c
);

   localparam int unsigned OFF_W  = off_w(PRECISION);
   localparam int unsigned CLIP_W = clip_w(PRECISION);

   // Upper data bits are don't-care for narrow fields
   logic unused_data_c;
   assign unused_data_c = ^wr_req.data;

   assign mapped_wr_c = wr_fire & is_mapped(wr_req.addr);

   // Shadow storage; unmapped ids fall through untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_mode        <= '0;
         shd_scale       <= '0;
         shd_offset_x    <= '0;
         shd_offset_y    <= '0;
         shd_clip_left   <= '0;
         shd_clip_right  <= '0;
         shd_clip_top    <= '0;
         shd_clip_bottom <= '0;
      end else if (wr_fire) begin
         case (wr_req.addr)
            REG_CLEAR: begin
               shd_mode        <= '0;
               shd_scale       <= '0;
               shd_offset_x    <= '0;
               shd_offset_y    <= '0;
               shd_clip_left   <= '0;
               shd_clip_right  <= '0;
               shd_clip_top    <= '0;
               shd_clip_bottom <= '0;
            end
            REG_MODE:        shd_mode        <= wr_req.data[1:0];
            REG_SCALE:       shd_scale       <= wr_req.data[1:0];
            REG_OFFSET_X:    shd_offset_x    <= wr_req.data[OFF_W-1:0];
            REG_OFFSET_Y:    shd_offset_y    <= wr_req.data[OFF_W-1:0];
            REG_CLIP_LEFT:   shd_clip_left   <= wr_req.data[CLIP_W-1:0];
            REG_CLIP_RIGHT:  shd_clip_right  <= wr_req.data[CLIP_W-1:0];
            REG_CLIP_TOP:    shd_clip_top    <= wr_req.data[CLIP_W-1:0];
            REG_CLIP_BOTTOM: shd_clip_bottom <= wr_req.data[CLIP_W-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_ctrl_sync.sv
// pipeline_ctrl_sync: frame-synchronous control register scheduler.
// Decoder writes land in shadow registers; all pending values are copied
// to the active ctrl_* outputs in one commit at the next vsync rising edge.
// Optional watchdog (macro PIPELINE_CTRL_WATCHDOG_EN) forces the commit
// after WATCHDOG_CYCLES pending cycles without a vsync edge.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data decoder write handshake
//   vsync                            vertical sync level (clk domain)
//   commit_hold                      defers commits while high
//   ctrl_*                           active control values
//   pending                          shadow holds uncommitted writes
//   commit_pulse                     first cycle of new ctrl_* values
//   frame_count                      vsync rising edges, wraps
import pipeline_ctrl_pkg::*;

module pipeline_ctrl_sync #(
   parameter int unsigned PRECISION       = 11,
   parameter int unsigned WATCHDOG_CYCLES = 2000000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [7:0]                    wr_addr,
   input  logic [15:0]                   wr_data,
   input  logic                          vsync,
   input  logic                          commit_hold,
   output logic [1:0]                    ctrl_overlay_mode,
   output logic [1:0]                    ctrl_fg_scale,
   output logic signed [PRECISION:0]     ctrl_fg_offset_x,
   output logic signed [PRECISION:0]     ctrl_fg_offset_y,
   output logic [PRECISION-1:0]          ctrl_fg_clip_left,
   output logic [PRECISION-1:0]          ctrl_fg_clip_right,
   output logic [PRECISION-1:0]          ctrl_fg_clip_top,
   output logic [PRECISION-1:0]          ctrl_fg_clip_bottom,
   output logic                          pending,
   output logic                          commit_pulse,
   output logic [7:0]                    frame_count
);

   state_e  state_q, state_d;
   wr_req_t wr_req;
   logic    wr_fire;
   logic    mapped_wr_c;
   logic    vsync_q;
   logic    vsync_edge;
   logic    wd_hit;

   logic [1:0]                 shd_mode, shd_scale;
   logic signed [PRECISION:0]  shd_offset_x, shd_offset_y;
   logic [PRECISION-1:0]       shd_clip_left, shd_clip_right;
   logic [PRECISION-1:0]       shd_clip_top, shd_clip_bottom;

   assign wr_req.addr = wr_addr;
   assign wr_req.data = wr_data;
   assign wr_fire     = wr_valid & wr_ready;
   assign vsync_edge  = vsync & ~vsync_q;

   pipeline_ctrl_shadow_regs #(
      .PRECISION (PRECISION)
   ) u_shadow (
      .clk             (clk),
      .rst_n           (rst_n),
      .wr_fire         (wr_fire),
      .wr_req          (wr_req),
      .shd_mode        (shd_mode),
      .shd_scale       (shd_scale),
      .shd_offset_x    (shd_offset_x),
      .shd_offset_y    (shd_offset_y),
      .shd_clip_left   (shd_clip_left),
      .shd_clip_right  (shd_clip_right),
      .shd_clip_top    (shd_clip_top),
      .shd_clip_bottom (shd_clip_bottom),
      .mapped_wr_c     (mapped_wr_c)
   );

`ifdef PIPELINE_CTRL_WATCHDOG_EN
   // Counts pending cycles without vsync; any interruption restarts it
   logic [31:0] wd_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
      end else if ((state_q != ST_PENDING) || commit_hold || vsync_edge) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_q + 32'd1;
      end
   end

   assign wd_hit = (state_q == ST_PENDING) && !commit_hold &&
                   (wd_cnt_q >= 32'(WATCHDOG_CYCLES));
`else
   localparam int unsigned unused_wd_cycles = WATCHDOG_CYCLES;
   assign wd_hit = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mapped_wr_c) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if ((vsync_edge && !commit_hold) || wd_hit) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State, status outputs, vsync history and frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         vsync_q      <= 1'b0;
         wr_ready     <= 1'b1;
         pending      <= 1'b0;
         commit_pulse <= 1'b0;
         frame_count  <= '0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync;
         wr_ready     <= (state_d != ST_COMMIT);
         pending      <= (state_d == ST_PENDING);
         commit_pulse <= (state_q == ST_COMMIT);
         if (vsync_edge) frame_count <= frame_count + 8'd1;
      end
   end

   // Active registers: copied from shadow as the COMMIT cycle ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_overlay_mode   <= '0;
         ctrl_fg_scale       <= '0;
         ctrl_fg_offset_x    <= '0;
         ctrl_fg_offset_y    <= '0;
         ctrl_fg_clip_left   <= '0;
         ctrl_fg_clip_right  <= '0;
         ctrl_fg_clip_top    <= '0;
         ctrl_fg_clip_bottom <= '0;
      end else if (state_q == ST_COMMIT) begin
         ctrl_overlay_mode   <= shd_mode;
         ctrl_fg_scale       <= shd_scale;
         ctrl_fg_offset_x    <= shd_offset_x;
         ctrl_fg_offset_y    <= shd_offset_y;
         ctrl_fg_clip_left   <= shd_clip_left;
         ctrl_fg_clip_right  <= shd_clip_right;
         ctrl_fg_clip_top    <= shd_clip_top;
         ctrl_fg_clip_bottom <= shd_clip_bottom;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl_sync.sv
// tb_pipeline_ctrl_sync: directed self-checking bench for pipeline_ctrl_sync.
// Table of single-write/vsync vectors plus hand-written multi-cycle sequences.
module tb_pipeline_ctrl_sync;

   localparam int unsigned PRECISION = 11;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      wr_valid = 1'b0;
   logic                      wr_ready;
   logic [7:0]                wr_addr = '0;
   logic [15:0]               wr_data = '0;
   logic                      vsync = 1'b0;
   logic                      commit_hold = 1'b0;
   logic [1:0]                ctrl_overlay_mode, ctrl_fg_scale;
   logic signed [PRECISION:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
   logic [PRECISION-1:0]      ctrl_fg_clip_left, ctrl_fg_clip_right;
   logic [PRECISION-1:0]      ctrl_fg_clip_top, ctrl_fg_clip_bottom;
   logic                      pending, commit_pulse;
   logic [7:0]                frame_count;

   int tests = 0;
   int fails = 0;

   pipeline_ctrl_sync #(
      .PRECISION       (PRECISION),
      .WATCHDOG_CYCLES (16)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .wr_valid            (wr_valid),
      .wr_ready            (wr_ready),
      .wr_addr             (wr_addr),
      .wr_data             (wr_data),
      .vsync               (vsync),
      .commit_hold         (commit_hold),
      .ctrl_overlay_mode   (ctrl_overlay_mode),
      .ctrl_fg_scale       (ctrl_fg_scale),
      .ctrl_fg_offset_x    (ctrl_fg_offset_x),
      .ctrl_fg_offset_y    (ctrl_fg_offset_y),
      .ctrl_fg_clip_left   (ctrl_fg_clip_left),
      .ctrl_fg_clip_right  (ctrl_fg_clip_right),
      .ctrl_fg_clip_top    (ctrl_fg_clip_top),
      .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom),
      .pending             (pending),
      .commit_pulse        (commit_pulse),
      .frame_count         (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      int mode, scale, offx, offy, cl, cr, ct, cb;
      int pend;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr_valid = 1'b0;
      vsync = 1'b0;
      commit_hold = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d);
      int n;
      n = 0;
      wr_addr = a;
      wr_data = d;
      wr_valid = 1'b1;
      while (!wr_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $display("FAIL write_timeout: wr_ready stayed %0d, expected 1", wr_ready);
      end
      tick();
      wr_valid = 1'b0;
   endtask

   // vsync high for one sampled edge, then low; returns after the commit edge
   task automatic vsync_pulse();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
   endtask

   task automatic check_ctrl(input string tag, input vec_t v);
      check({tag, " mode"},  int'(ctrl_overlay_mode),   v.mode);
      check({tag, " scale"}, int'(ctrl_fg_scale),       v.scale);
      check({tag, " offx"},  int'(ctrl_fg_offset_x),    v.offx);
      check({tag, " offy"},  int'(ctrl_fg_offset_y),    v.offy);
      check({tag, " clipl"}, int'(ctrl_fg_clip_left),   v.cl);
      check({tag, " clipr"}, int'(ctrl_fg_clip_right),  v.cr);
      check({tag, " clipt"}, int'(ctrl_fg_clip_top),    v.ct);
      check({tag, " clipb"}, int'(ctrl_fg_clip_bottom), v.cb);
   endtask

   initial begin
      vec_t zero;
      int   n;

      //              addr   data      mode sc offx  offy   cl    cr   ct  cb   pend
      vecs[0]  = '{8'h01, 16'h0002, 2, 0,    0,     0,    0,   0,  0,   0, 1};
      vecs[1]  = '{8'h03, 16'h0003, 2, 3,    0,     0,    0,   0,  0,   0, 1};
      vecs[2]  = '{8'h05, 16'h07FF, 2, 3,    0,  2047,    0,   0,  0,   0, 1};
      vecs[3]  = '{8'h05, 16'hF800, 2, 3,    0, -2048,    0,   0,  0,   0, 1};
      vecs[4]  = '{8'h07, 16'hFFFF, 2, 3,    0, -2048, 2047,   0,  0,   0, 1};
      vecs[5]  = '{8'h08, 16'h0280, 2, 3,    0, -2048, 2047, 640,  0,   0, 1};
      vecs[6]  = '{8'h09, 16'h0055, 2, 3,    0, -2048, 2047, 640, 85,   0, 1};
      vecs[7]  = '{8'h02, 16'h1234, 2, 3,    0, -2048, 2047, 640, 85,   0, 0};
      vecs[8]  = '{8'h0A, 16'h01E0, 2, 3,    0, -2048, 2047, 640, 85, 480, 1};
      vecs[9]  = '{8'h00, 16'h0000, 0, 0,    0,     0,    0,   0,  0,   0, 1};
      vecs[10] = '{8'h04, 16'h0F38, 0, 0, -200,     0,    0,   0,  0,   0, 1};
      vecs[11] = '{8'h06, 16'hFFFF, 0, 0, -200,     0,    0,   0,  0,   0, 0};
      zero = '{8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      // Reset state
      do_reset();
      check_ctrl("reset", zero);
      check("reset pending", int'(pending), 0);
      check("reset commit_pulse", int'(commit_pulse), 0);
      check("reset frame_count", int'(frame_count), 0);
      check("reset wr_ready", int'(wr_ready), 1);

      // Table: one write, then a vsync pulse that commits it
      foreach (vecs[i]) begin
         do_write(vecs[i].addr, vecs[i].data);
         check($sformatf("vec%0d pending", i), int'(pending), vecs[i].pend);
         vsync_pulse();
         check($sformatf("vec%0d commit_pulse", i), int'(commit_pulse), vecs[i].pend);
         check_ctrl($sformatf("vec%0d", i), vecs[i]);
         tick();
      end
      check("table frame_count", int'(frame_count), 12);

      // Commit latency: values change two edges after vsync sampled high
      do_reset();
      do_write(8'h04, 16'h0F38);
      check("lat pending", int'(pending), 1);
      check("lat offx before", int'(ctrl_fg_offset_x), 0);
      vsync = 1'b1;
      tick();
      check("lat offx in commit", int'(ctrl_fg_offset_x), 0);
      check("lat pulse in commit", int'(commit_pulse), 0);
      check("lat wr_ready in commit", int'(wr_ready), 0);
      tick();
      check("lat offx after", int'(ctrl_fg_offset_x), -200);
      check("lat pulse after", int'(commit_pulse), 1);
      check("lat pending after", int'(pending), 0);
      check("lat wr_ready after", int'(wr_ready), 1);
      tick();
      check("lat pulse one cycle", int'(commit_pulse), 0);
      vsync = 1'b0;
      tick();

      // Last write wins; fields of one commit update together
      do_write(8'h01, 16'h0002);
      do_write(8'h01, 16'h0003);
      do_write(8'h0A, 16'h01E0);
      vsync = 1'b1;
      tick();
      check("multi mode old", int'(ctrl_overlay_mode), 0);
      check("multi clipb old", int'(ctrl_fg_clip_bottom), 0);
      tick();
      check("multi mode new", int'(ctrl_overlay_mode), 3);
      check("multi clipb new", int'(ctrl_fg_clip_bottom), 480);
      vsync = 1'b0;
      tick();
      do_write(8'h55, 16'hFFFF);
      check("unmapped pending", int'(pending), 0);
      vsync_pulse();
      check("unmapped no pulse", int'(commit_pulse), 0);
      check("unmapped mode", int'(ctrl_overlay_mode), 3);
      check("unmapped clipb", int'(ctrl_fg_clip_bottom), 480);

      // Write presented during COMMIT stalls one cycle and lands after
      do_write(8'h03, 16'h0002);
      check("stall ready before", int'(wr_ready), 1);
      vsync = 1'b1;
      tick();
      wr_addr = 8'h03;
      wr_data = 16'h0001;
      wr_valid = 1'b1;
      check("stall ready in commit", int'(wr_ready), 0);
      tick();
      check("stall scale committed", int'(ctrl_fg_scale), 2);
      check("stall ready after", int'(wr_ready), 1);
      check("stall pending mid", int'(pending), 0);
      tick();
      wr_valid = 1'b0;
      check("stall pending after", int'(pending), 1);
      check("stall scale held", int'(ctrl_fg_scale), 2);
      vsync = 1'b0;
      tick();
      vsync_pulse();
      check("stall second commit", int'(ctrl_fg_scale), 1);
      check("stall second pulse", int'(commit_pulse), 1);

      // Hold skips vsync edges; release waits for the next edge
      do_reset();
      do_write(8'h03, 16'h0001);
      commit_hold = 1'b1;
      vsync_pulse();
      check("hold pulse1", int'(commit_pulse), 0);
      vsync_pulse();
      check("hold pulse2", int'(commit_pulse), 0);
      check("hold scale", int'(ctrl_fg_scale), 0);
      check("hold frame_count", int'(frame_count), 2);
      commit_hold = 1'b0;
      repeat (3) tick();
      check("hold release pending", int'(pending), 1);
      check("hold release scale", int'(ctrl_fg_scale), 0);
      vsync_pulse();
      check("hold commit scale", int'(ctrl_fg_scale), 1);
      check("hold commit pulse", int'(commit_pulse), 1);
      check("hold frame_count3", int'(frame_count), 3);
      tick();

      // Reset mid-operation drops uncommitted shadow data
      do_write(8'h01, 16'h0001);
      check("rst pending before", int'(pending), 1);
      rst_n = 1'b0;
      #2;
      check("rst pending", int'(pending), 0);
      check("rst scale", int'(ctrl_fg_scale), 0);
      check("rst frame_count", int'(frame_count), 0);
      check("rst wr_ready", int'(wr_ready), 1);
      tick();
      rst_n = 1'b1;
      tick();
      vsync_pulse();
      check("rst no commit", int'(commit_pulse), 0);
      check("rst mode", int'(ctrl_overlay_mode), 0);
      check("rst still idle", int'(pending), 0);
      tick();

      // Pending with no vsync at all
      do_write(8'h08, 16'h0005);
`ifdef PIPELINE_CTRL_WATCHDOG_EN
      n = 0;
      while (!commit_pulse && n < 100) begin
         tick();
         n++;
      end
      check("wd commit cycles", n, 18);
      check("wd clipr", int'(ctrl_fg_clip_right), 5);
      check("wd frame_count", int'(frame_count), 1);
`else
      n = 0;
      repeat (1000) tick();
      check("nowd pending", int'(pending), 1);
      check("nowd clipr", int'(ctrl_fg_clip_right), n);
`endif

      // Frame counter wraps 255 -> 0
      do_reset();
      repeat (255) vsync_pulse();
      check("fc 255", int'(frame_count), 255);
      vsync_pulse();
      check("fc wrap", int'(frame_count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl_sync.md
# pipeline_ctrl_sync

Frame-synchronous control register scheduler between the SPI command decoder and the overlay pipeline. Register writes from the decoder land in shadow registers. All pending shadow values are copied to the active `ctrl_*` outputs in a single commit at the next vsync rising edge, so overlay mode, scale, offset and clip never change mid-frame. An optional watchdog forces the commit when no vsync arrives, for example when no input signal is present.

## Interface
- `PRECISION`, 11: width base for positions; offsets are PRECISION+1 bits signed, clips are PRECISION bits.
- `WATCHDOG_CYCLES`, 2000000: cycles pending without a vsync edge before a forced commit (macro-enabled only).
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: decoder write request.
- `wr_ready` out 1: write accepted when `wr_valid & wr_ready`.
- `wr_addr` in 8: register id, uses the command id codes.
- `wr_data` in 16: write data; low bits used per field.
- `vsync` in 1: vertical sync level, synchronous to `clk`, active high.
- `commit_hold` in 1: defers commits while high.
- `ctrl_overlay_mode` out 2: active overlay mode.
- `ctrl_fg_scale` out 2: active foreground scale.
- `ctrl_fg_offset_x`, `ctrl_fg_offset_y` out PRECISION+1, signed: active foreground offsets.
- `ctrl_fg_clip_left`, `ctrl_fg_clip_right`, `ctrl_fg_clip_top`, `ctrl_fg_clip_bottom` out PRECISION each: active clip values.
- `pending` out 1: shadow holds uncommitted writes.
- `commit_pulse` out 1: one cycle, coincident with the first cycle of new `ctrl_*` values.
- `frame_count` out 8: vsync rising edges seen, wraps 255→0.

## Operation
- **Reset.** All shadow and active registers are 0. State is IDLE. `pending`=0, `commit_pulse`=0, `frame_count`=0, `wr_ready`=1, internal `vsync_q`=0, watchdog counter=0.
- **Address map.**
  - 0x01: mode ← `wr_data[1:0]`.
  - 0x03: scale ← `wr_data[1:0]`.
  - 0x04, 0x05: offset x, offset y ← `wr_data[PRECISION:0]`.
  - 0x07–0x0A: clip left, right, top, bottom ← `wr_data[PRECISION-1:0]`.
  - 0x00: clears every shadow field to 0.
  - All of the above set pending. Any other address is accepted, ignored, and leaves state unchanged.
- **Vsync edge.** `vsync_edge` = `vsync & ~vsync_q`. Every edge increments `frame_count`, independent of state.
- **States.**
  - IDLE: an accepted mapped write → PENDING.
  - PENDING: `vsync_edge & ~commit_hold` → COMMIT. Further writes are accepted and overwrite shadow fields (last write wins).
  - COMMIT: lasts one cycle. `wr_ready`=0. Active ← shadow. → IDLE.
- `pending` = (state==PENDING).
- **Hold.** A vsync edge during hold is skipped. Releasing hold does not commit; the commit waits for the next vsync edge.
- **Reset mid-operation.** Returns to reset values. Uncommitted shadow data is lost.

## Timing
- A write accepted at edge k is in shadow after k. If edge k also moves PENDING→COMMIT, that write is included in the commit.
- vsync first sampled high at edge k in PENDING (hold low) → COMMIT during cycle k..k+1 → `ctrl_*` updated and `commit_pulse`=1 after edge k+1, for one cycle.
- `wr_valid` during COMMIT stalls exactly one cycle. The write must stay stable and is accepted at the next edge.
- A vsync edge cannot occur in COMMIT, since `vsync_q`=1 there.
- A vsync edge in IDLE only increments `frame_count`.

## Configuration
- `PIPELINE_CTRL_WATCHDOG_EN` defined:
  - A 32-bit counter counts cycles while in PENDING with `commit_hold` low.
  - It clears on `vsync_edge`, on leaving PENDING, and while hold is high.
  - Reaching `WATCHDOG_CYCLES` → COMMIT, with the same one-cycle commit timing.
  - `frame_count` is not incremented by a forced commit.
- Undefined: no counter. PENDING waits for a vsync edge indefinitely.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - register id constants 0x00–0x0A, shared with the SPI command decoder;
  - state encoding IDLE/PENDING/COMMIT;
  - field width helpers derived from PRECISION.
- Sub-module `pipeline_ctrl_shadow_regs` handles address decode, shadow storage and the mapped-write indication.
- The top level holds the FSM, vsync edge detect, watchdog, frame counter and active registers.

## Test plan
- Reset, then write 0x04 = 0x0F38 with vsync low → `pending`=1 and `ctrl_fg_offset_x`=0. Raise vsync → `ctrl_fg_offset_x`=-200 two edges after vsync first sampled high, with `commit_pulse` high for one cycle.
- Write 0x01=2, then 0x01=3, then 0x0A=0x1E0, then pulse vsync → mode=3 and clip_bottom=480 update in the same cycle. Write 0x55 alone → no pending, no change on vsync.
- Hold `wr_valid` high across a commit → `wr_ready`=0 exactly in the COMMIT cycle. The second write lands in shadow, `pending`=1 afterwards, and it commits on the next vsync.
- `commit_hold`=1 with a pending write 0x03=1, two vsync edges → no commit and `frame_count`=2. Release hold → no commit until the third edge, then scale=1.
- Pending write, `rst_n` low mid-frame → all outputs 0, IDLE. A following vsync produces no commit.
- With `PIPELINE_CTRL_WATCHDOG_EN` and `WATCHDOG_CYCLES`=16: pending write with no vsync → commit 17–18 cycles after entry to PENDING. Without the macro → still pending after 1000 cycles.
